// File: rtl/nova_io_pio_trace_pkg.sv
// rtl/nova_io_pio_trace_pkg.sv - shared bus widths, register selects, status/entry layouts
package nova_io_pio_trace_pkg;

  localparam int ADR_W   = 8;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = 1 + ADR_W + DATA_W;
  localparam int CNT_W   = 9;

  // Register select values carried in bs_adr[6:7]
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_HEAD   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_DROPS  = 2'd3;

  // Control bits of a register-0 write, in the bus's [0:15] bit numbering
  localparam int CTL_EN_BIT    = 15;
  localparam int CTL_FLUSH_BIT = 14;

  typedef struct packed {
    logic             en;
    logic             ovf;
    logic             full;
    logic             empty;
    logic [2:0]       rsvd;
    logic [CNT_W-1:0] count;
  } status_t;

  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [DATA_W-1:0] head_header(entry_t e);
    return {e.we, 7'b0, e.adr};
  endfunction

endpackage

// File: rtl/nova_fifo.sv
// rtl/nova_fifo.sv - generic single-clock FIFO with flush, occupancy-based full/empty
module nova_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH; occupancy alone decides full/empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; stale words are unreachable once count is zero
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nova_io_pio_trace.sv
// rtl/nova_io_pio_trace.sv - I/O bus transaction tracer with readback FIFO
module nova_io_pio_trace
  import nova_io_pio_trace_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [5:0] DEVCODE = 6'o50,
  parameter logic [5:0] MATCH   = 6'o00,
  parameter logic [5:0] MASK    = 6'o00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bs_stb,
  input  logic        bs_we,
  input  logic [0:7]  bs_adr,
  input  logic [0:15] bs_din,
  output logic [0:15] bs_dout
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [5:0]         dev;
  logic [1:0]         rsel;
  logic               hit;
  logic               capture;
  logic               drop;
  logic               wr_status;
  logic               wr_drops;
  logic               do_flush;
  logic               do_pop;
  logic               en;
  logic               ovf;
  logic [15:0]        drops;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_bits;
  entry_t             head;
  entry_t             entry_in;
  status_t            status;

  assign dev  = bs_adr[0:5];
  assign rsel = bs_adr[6:7];

  // Own accesses are excluded from capture so a tracer read never traces itself
  assign hit       = bs_stb && (dev == DEVCODE);
  assign capture   = bs_stb && en && !hit && ((dev & MASK) == (MATCH & MASK));
  assign drop      = capture && fifo_full;
  assign wr_status = hit && bs_we && (rsel == REG_STATUS);
  assign wr_drops  = hit && bs_we && (rsel == REG_DROPS);
  assign do_flush  = wr_status && bs_din[CTL_FLUSH_BIT];
  assign do_pop    = hit && !bs_we && (rsel == REG_DATA);

  assign entry_in = '{we: bs_we, adr: bs_adr, data: bs_din};
  assign head     = entry_t'(head_bits);

  nova_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (do_pop),
    .flush (do_flush),
    .din   (entry_in),
    .dout  (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Enable, sticky overflow and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en    <= 1'b0;
      ovf   <= 1'b0;
      drops <= '0;
    end else begin
      if (wr_status) begin
        en <= bs_din[CTL_EN_BIT];
        if (bs_din[CTL_FLUSH_BIT]) ovf <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
      end
      if (wr_drops)                      drops <= '0;
      else if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
    end
  end

  always_comb begin
    status       = '0;
    status.en    = en;
    status.ovf   = ovf;
    status.full  = fifo_full;
    status.empty = fifo_empty;
    status.count = CNT_W'(fifo_count);
  end

  // Zero-latency readback; bus is driven only for reads of our own device
  always_comb begin
    bs_dout = '0;
    if (!rst && hit && !bs_we) begin
      case (rsel)
        REG_STATUS: bs_dout = status;
        REG_HEAD:   bs_dout = fifo_empty ? 16'h0 : head_header(head);
        REG_DATA:   bs_dout = fifo_empty ? 16'h0 : head.data;
        default:    bs_dout = drops;
      endcase
    end
  end

endmodule

// File: tb/tb_nova_io_pio_trace.sv
// tb/tb_nova_io_pio_trace.sv - self-checking bench for nova_io_pio_trace
module tb_nova_io_pio_trace;

  localparam logic [5:0] DEV   = 6'o50;
  localparam int         DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb_a = 1'b0;
  logic        stb_b = 1'b0;
  logic        bs_we = 1'b0;
  logic [7:0]  bs_adr = '0;
  logic [15:0] bs_din = '0;
  logic [15:0] dout_a;
  logic [15:0] dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nova_io_pio_trace dut_a (
    .clk(clk), .rst(rst), .bs_stb(stb_a), .bs_we(bs_we),
    .bs_adr(bs_adr), .bs_din(bs_din), .bs_dout(dout_a)
  );

  nova_io_pio_trace #(.MATCH(6'o10), .MASK(6'o77)) dut_b (
    .clk(clk), .rst(rst), .bs_stb(stb_b), .bs_we(bs_we),
    .bs_adr(bs_adr), .bs_din(bs_din), .bs_dout(dout_b)
  );

  // Reference model: one queue of captured entries per instance
  bit          m_en   [2];
  bit          m_ovf  [2];
  int          m_drops[2];
  logic [5:0]  m_match[2];
  logic [5:0]  m_mask [2];
  logic [24:0] q0[$];
  logic [24:0] q1[$];

  function automatic int qsize(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [24:0] qhead(int i);
    if (qsize(i) == 0) return '0;
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [15:0] model_read(int i, logic [7:0] adr);
    int          n = qsize(i);
    logic [24:0] h = qhead(i);
    case (adr[1:0])
      2'd0:    return {m_en[i], m_ovf[i], n == DEPTH, n == 0, 3'b000, 9'(n)};
      2'd1:    return (n > 0) ? {h[24], 7'b0, h[23:16]} : 16'h0;
      2'd2:    return (n > 0) ? h[15:0] : 16'h0;
      default: return m_drops[i][15:0];
    endcase
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_en[i] = 0; m_ovf[i] = 0; m_drops[i] = 0;
    end
  endtask

  task automatic model_apply(int i, bit we, logic [7:0] adr, logic [15:0] din);
    if (adr[7:2] == DEV) begin
      if (we) begin
        if (adr[1:0] == 2'd0) begin
          m_en[i] = din[0];
          if (din[1]) begin
            if (i == 0) q0.delete(); else q1.delete();
            m_ovf[i] = 0;
          end
        end else if (adr[1:0] == 2'd3) begin
          m_drops[i] = 0;
        end
      end else if (adr[1:0] == 2'd2 && qsize(i) > 0) begin
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end else if (m_en[i] && ((adr[7:2] & m_mask[i]) == (m_match[i] & m_mask[i]))) begin
      if (qsize(i) < DEPTH) begin
        if (i == 0) q0.push_back({we, adr, din}); else q1.push_back({we, adr, din});
      end else begin
        m_ovf[i] = 1;
        if (m_drops[i] < 65535) m_drops[i]++;
      end
    end
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe cycle on instance i; read data checked before the edge
  task automatic bus(int i, bit we, logic [7:0] adr, logic [15:0] din, string tag);
    logic [15:0] exp;
    exp = (!we && adr[7:2] == DEV) ? model_read(i, adr) : 16'h0;
    bs_we = we; bs_adr = adr; bs_din = din;
    if (i == 0) stb_a = 1'b1; else stb_b = 1'b1;
    @(negedge clk);
    check(tag, (i == 0) ? dout_a : dout_b, exp);
    @(posedge clk);
    #1;
    stb_a = 1'b0; stb_b = 1'b0;
    model_apply(i, we, adr, din);
  endtask

  task automatic reg_wr(int i, logic [1:0] r, logic [15:0] d);
    bus(i, 1'b1, {DEV, r}, d, "reg_write");
  endtask

  task automatic reg_rd(int i, logic [1:0] r, string tag);
    bus(i, 1'b0, {DEV, r}, 16'($urandom), tag);
  endtask

  task automatic cap(int i, logic [5:0] dev, bit we, logic [15:0] d);
    bus(i, we, {dev, 2'($urandom)}, d, "capture_cycle");
  endtask

  function automatic logic [5:0] rand_dev();
    logic [5:0] d = 6'($urandom);
    return (d == DEV) ? 6'o10 : d;
  endfunction

  task automatic reset_pulse(string tag);
    rst = 1'b1;
    stb_a = 1'b1; bs_we = 1'b0; bs_adr = {DEV, 2'd0};
    #1;
    check(tag, dout_a, 16'h0);
    bs_adr = {DEV, 2'd2};
    #1;
    check({tag, "_data"}, dout_a, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; stb_a = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    m_match[0] = 6'o00; m_mask[0] = 6'o00;
    m_match[1] = 6'o10; m_mask[1] = 6'o77;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    reset_pulse("reset_dout");
    reg_rd(0, 2'd0, "reset_status");
    reg_rd(0, 2'd3, "reset_drops");

    // Disabled tracer ignores traffic
    for (int k = 0; k < 4; k++) cap(0, 6'o10, 1'b1, 16'($urandom));
    reg_rd(0, 2'd0, "disabled_status");
    reg_rd(0, 2'd3, "disabled_drops");

    // Basic capture of three writes, header/data readback, then empty
    reg_wr(0, 2'd0, 16'h0001);
    for (int k = 1; k <= 3; k++) cap(0, 6'o10, 1'b1, 16'(k));
    reg_rd(0, 2'd0, "count3_status");
    for (int k = 0; k < 3; k++) begin
      reg_rd(0, 2'd1, "head_header");
      reg_rd(0, 2'd2, "head_data");
    end
    reg_rd(0, 2'd0, "empty_status");

    // Overflow: 20 captures into 16 entries, room restored after one pop
    for (int k = 0; k < 20; k++) cap(0, rand_dev(), 1'($urandom), 16'($urandom));
    reg_rd(0, 2'd0, "full_status");
    reg_rd(0, 2'd3, "drops4");
    reg_rd(0, 2'd2, "pop_from_full");
    cap(0, rand_dev(), 1'b0, 16'($urandom));
    reg_rd(0, 2'd0, "refill_status");
    reg_rd(0, 2'd3, "drops_after_refill");
    for (int k = 0; k < DEPTH; k++) reg_rd(0, 2'd2, "drain_data");

    // Empty pop is harmless; drops clear; writes to regs 1/2 ignored
    reg_rd(0, 2'd2, "empty_pop");
    reg_rd(0, 2'd0, "empty_pop_status");
    reg_wr(0, 2'd1, 16'hFFFF);
    reg_wr(0, 2'd2, 16'hFFFF);
    reg_rd(0, 2'd0, "ignored_writes_status");
    reg_wr(0, 2'd3, 16'h0000);
    reg_rd(0, 2'd3, "drops_cleared");

    // Masked match on instance B: only device 6'o10 is traced
    reg_wr(1, 2'd0, 16'h0001);
    for (int k = 0; k < 12; k++) begin
      cap(1, ($urandom_range(0, 1) == 0) ? 6'o10 : 6'o11, 1'($urandom), 16'($urandom));
      if (k % 4 == 3) reg_rd(1, 2'd0, "masked_status");
    end
    n = q1.size();
    for (int k = 0; k <= n; k++) begin
      reg_rd(1, 2'd1, "masked_header");
      reg_rd(1, 2'd2, "masked_data");
    end
    reg_rd(1, 2'd0, "masked_empty");

    // Flush with enable kept, then reset in the middle of filling
    for (int k = 0; k < 5; k++) cap(0, rand_dev(), 1'b1, 16'($urandom));
    reg_rd(0, 2'd0, "five_status");
    reg_wr(0, 2'd0, 16'h0003);
    reg_rd(0, 2'd0, "flush_status");
    for (int k = 0; k < 3; k++) cap(0, rand_dev(), 1'b1, 16'($urandom));
    reg_wr(1, 2'd0, 16'h0001);
    cap(1, 6'o10, 1'b1, 16'h1234);
    reset_pulse("reset_mid");
    reg_rd(0, 2'd0, "post_reset_status");
    reg_rd(1, 2'd0, "post_reset_status_b");
    cap(0, rand_dev(), 1'b1, 16'($urandom));
    cap(0, rand_dev(), 1'b0, 16'($urandom));
    reg_rd(0, 2'd0, "post_reset_no_capture");
    reg_wr(0, 2'd0, 16'h0001);

    // Randomized traffic against the queue model
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: cap(0, rand_dev(), 1'($urandom), 16'($urandom));
        5:             reg_rd(0, 2'($urandom), "rand_read");
        6, 7:          reg_rd(0, 2'd2, "rand_pop");
        8:             reg_wr(0, 2'd0, {14'($urandom),
                                        1'($urandom_range(0, 4) == 0),
                                        1'($urandom_range(0, 5) != 0)});
        default:       reg_wr(0, 2'($urandom_range(1, 3)), 16'($urandom));
      endcase
    end
    reg_rd(0, 2'd0, "final_status");
    reg_rd(0, 2'd3, "final_drops");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
